// File: rtl/ff_exerciser_pkg.sv
// ff_exerciser_pkg: shared op encodings, FSM states and LFSR constants for the flip-flop exerciser
package ff_exerciser_pkg;
  localparam logic [1:0] OP_DATA0 = 2'b00;
  localparam logic [1:0] OP_DATA1 = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_RST = 2'b11;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE} state_t;
endpackage

// File: rtl/ff_exerciser_lfsr.sv
// ff_exerciser_lfsr: 8-bit Fibonacci stimulus LFSR with load and step enables
module ff_exerciser_lfsr
  import ff_exerciser_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  output logic [7:0] stepped
);
  logic [7:0] lfsr;
  assign stepped = {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  always_ff @(posedge clk) begin
    if (reset || load) lfsr <= SEED;
    else if (step) lfsr <= stepped;
  end
endmodule

// File: rtl/ff_exerciser.sv
// ff_exerciser: drives a set/reset D flip-flop with LFSR vectors and counts q mismatches
module ff_exerciser
  import ff_exerciser_pkg::*;
#(
  parameter int NUM_VECTORS = 64,
  parameter int SETTLE_CYCLES = 2,
  parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEFAULT,
  parameter int ERR_W = 8,
  localparam int VW = $clog2(NUM_VECTORS) + 1,
  localparam int CW = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ff_q,
  output logic             ff_d,
  output logic             ff_set,
  output logic             ff_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VW-1:0]    vec_index
);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [7:0] lfsr_step, vec;
  logic [1:0] op;
  logic [VW-1:0] vec_n;
  logic [ERR_W-1:0] err_n;
  logic accept, step, last, entering, q_n, exp_q;

  ff_exerciser_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk(clk), .reset(reset), .load(accept), .step(step), .stepped(lfsr_step)
  );

  // Outputs are registered from the next-state view so the APPLY cycle already carries its vector.
  always_comb begin
    accept = (state == S_IDLE || state == S_DONE) && start;
    step = state == S_SAMPLE;
    last = vec_index == VW'(NUM_VECTORS - 1);
    state_n = accept ? S_APPLY
            : state == S_APPLY ? S_SETTLE
            : state == S_SETTLE && cnt == '0 ? S_SAMPLE
            : step ? (last ? S_DONE : S_APPLY)
            : state;
    entering = state_n == S_APPLY;
    vec_n = accept ? '0 : step ? vec_index + VW'(1) : vec_index;
    vec = accept ? LFSR_SEED : lfsr_step;
    op = vec_n == '0 ? OP_RST : vec[1:0];
    q_n = op == OP_SET ? 1'b1 : op == OP_RST ? 1'b0 : vec[2];
    err_n = accept ? '0
          : step && ff_q != exp_q && err_count != '1 ? err_count + ERR_W'(1)
          : err_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      vec_index <= '0;
      err_count <= '0;
      exp_q <= 1'b0;
      ff_d <= 1'b0;
      ff_set <= 1'b0;
      ff_reset <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == S_APPLY ? CW'(SETTLE_CYCLES - 1) : cnt - CW'(state == S_SETTLE);
      vec_index <= vec_n;
      err_count <= err_n;
      ff_set <= entering && op == OP_SET;
      ff_reset <= entering && op == OP_RST;
      if (entering) begin
        exp_q <= q_n;
        ff_d <= q_n;
      end
      busy <= state_n == S_APPLY || state_n == S_SETTLE || state_n == S_SAMPLE;
      done <= state_n == S_DONE;
      pass <= state_n == S_DONE && err_n == '0;
    end
  end
endmodule

// File: tb/tb_ff_exerciser.sv
// tb_ff_exerciser: scoreboard bench with flip-flop models and an LFSR reference sequence
module tb_ff_exerciser;
  logic clk = 0, reset = 1, start = 0, start4 = 0;
  int mode = 0;
  logic q_m, q4;
  logic ff_q, ff_d, ff_set, ff_reset, busy, done, pass;
  logic [7:0] err_count;
  logic [6:0] vec_index;
  logic ff_d4, ff_set4, ff_reset4, busy4, done4, pass4;
  logic [3:0] err4;
  logic [6:0] vec4;

  typedef struct {logic s; logic r; logic d;} vexp_t;
  vexp_t vq[$];
  int rq_err[$];
  logic [1:0] ref_op[64];
  logic ref_q[64];
  int n_chk = 0, n_err = 0, ones = 0, phase = 0;
  logic busy_q = 0, done_q = 0, done4_q = 0;
  vexp_t cur;

  always #5 clk = ~clk;

  ff_exerciser dut (
    .clk(clk), .reset(reset), .start(start), .ff_q(ff_q), .ff_d(ff_d), .ff_set(ff_set),
    .ff_reset(ff_reset), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .vec_index(vec_index)
  );
  ff_exerciser #(.ERR_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .ff_q(~q4), .ff_d(ff_d4), .ff_set(ff_set4),
    .ff_reset(ff_reset4), .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .vec_index(vec4)
  );

  // Flip-flops under test: async reset beats async set, otherwise d is clocked in.
  always @(posedge clk or posedge ff_set or posedge ff_reset)
    q_m <= ff_reset ? 1'b0 : ff_set ? 1'b1 : ff_d;
  always @(posedge clk or posedge ff_set4 or posedge ff_reset4)
    q4 <= ff_reset4 ? 1'b0 : ff_set4 ? 1'b1 : ff_d4;
  assign ff_q = mode == 0 ? q_m : 1'b0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: APPLY is the first busy cycle and then every SETTLE_CYCLES+2 cycles.
  always @(negedge clk) begin
    if (busy) begin
      phase = !busy_q ? 0 : (phase + 1) % 4;
      if (phase == 0) begin
        if (vq.size() == 0) chk("vec_queue_empty", 1, 0);
        else begin
          cur = vq.pop_front();
          chk("apply_set", ff_set, cur.s);
          chk("apply_reset", ff_reset, cur.r);
          chk("apply_d", ff_d, cur.d);
        end
      end else begin
        chk("hold_set_low", ff_set, 0);
        chk("hold_reset_low", ff_reset, 0);
        chk("hold_d", ff_d, cur.d);
      end
    end
    if (ff_set && ff_reset) chk("set_reset_overlap", 1, 0);
    if (done && !done_q) begin
      if (rq_err.size() == 0) chk("result_queue_empty", 1, 0);
      else begin
        int e;
        e = rq_err.pop_front();
        chk("err_count", err_count, e);
        chk("pass", pass, e == 0);
      end
    end
    if (done4 && !done4_q) begin
      chk("err4_saturated", err4, 15);
      chk("pass4", pass4, 0);
    end
    busy_q = busy;
    done_q = done;
    done4_q = done4;
  end

  task automatic push_run(int exp_err);
    for (int k = 0; k < 64; k++) vq.push_back('{ref_op[k] == 2'd2, ref_op[k] == 2'd3, ref_q[k]});
    rq_err.push_back(exp_err);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_done(int exp_len);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_len >= 0) chk("run_length", n, exp_len);
    else chk("done_reached", done, 1);
  endtask

  task automatic wait_vec(int v);
    int n = 0;
    while (vec_index != v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_vec", vec_index, v);
  endtask

  initial begin
    logic [7:0] v;
    v = 8'hA5;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      ref_op[k] = k == 0 ? 2'd3 : v[1:0];
      ref_q[k] = ref_op[k] == 2'd2 ? 1'b1 : ref_op[k] == 2'd3 ? 1'b0 : v[2];
      ones += int'(ref_q[k]);
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_vec", vec_index, 0);
    chk("rst_outs", {ff_d, ff_set, ff_reset}, 0);
    reset = 0;
    // Correct flip-flop.
    push_run(0);
    pulse_start();
    wait_done(256);
    // Stuck-at-0 flip-flop.
    mode = 1;
    push_run(ones);
    pulse_start();
    wait_done(256);
    chk("stuck_err_nonzero", err_count != 0, 1);
    // Restart from DONE, with an ignored start mid-run.
    mode = 0;
    push_run(0);
    pulse_start();
    chk("restart_done_clr", done, 0);
    chk("restart_err_clr", err_count, 0);
    wait_vec(20);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("no_restart", vec_index >= 20, 1);
    wait_done(-1);
    // Reset mid-run at vector 10 with errors accumulating.
    mode = 1;
    push_run(ones);
    pulse_start();
    wait_vec(10);
    reset = 1;
    @(negedge clk) reset = 0;
    vq.delete();
    rq_err.delete();
    chk("abort_busy", busy, 0);
    chk("abort_setrst", {ff_set, ff_reset}, 0);
    chk("abort_err", err_count, 0);
    chk("abort_vec", vec_index, 0);
    mode = 0;
    push_run(0);
    pulse_start();
    wait_done(256);
    // Reset and start together: reset wins.
    @(negedge clk) begin reset = 1; start = 1; end
    @(negedge clk) begin reset = 0; start = 0; end
    chk("rst_over_start_busy", busy, 0);
    chk("rst_over_start_done", done, 0);
    repeat (2) @(negedge clk);
    chk("rst_over_start_idle", busy, 0);
    // Inverted flip-flop on the 4-bit error counter.
    @(negedge clk) start4 = 1;
    @(negedge clk) start4 = 0;
    begin
      int n = 0;
      while (!done4 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("done4_reached", done4, 1);
    end
    repeat (3) @(negedge clk);
    chk("err4_holds", err4, 15);
    chk("vec_queue_drained", vq.size(), 0);
    chk("result_queue_drained", rq_err.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
